// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-port controller for the 16x32 dual-port register file.
// Round-robin arbitration of the ALU (src0) and load (src1) writeback
// requesters onto the single DPRF write port, plus a clear sweep that writes
// CLEAR_VALUE to every register after reset and whenever clear_req is seen.
module rf_wb_arbiter #(
    parameter int               NUM_REGS       = 16,
    parameter int               REG_BITS       = 4,
    parameter int               DBITS          = 32,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DBITS-1:0] CLEAR_VALUE    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                src0_valid,
    input  logic [REG_BITS-1:0] src0_dest,
    input  logic [DBITS-1:0]    src0_data,
    output logic                src0_ready,
    input  logic                src1_valid,
    input  logic [REG_BITS-1:0] src1_dest,
    input  logic [DBITS-1:0]    src1_data,
    output logic                src1_ready,
    input  logic                clear_req,
    output logic                rf_we,
    output logic [REG_BITS-1:0] rf_regsel_dest,
    output logic [DBITS-1:0]    rf_datain,
    output logic                busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [REG_BITS-1:0] clr_idx_q, clr_idx_d;
    logic                last_grant_q, last_grant_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_BITS-1:0] rf_dest_q, rf_dest_d;
    logic [DBITS-1:0]    rf_data_q, rf_data_d;
    logic                grant0, grant1, run_open;

    // State register and registered write-port outputs; reset restarts the sweep at register 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx_q    <= '0;
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_dest_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_dest_q    <= rf_dest_d;
            rf_data_q    <= rf_data_d;
        end
    end

    // Next-state logic: the sweep ends on the edge that issues the last register; clear_req restarts it.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = '0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic: round-robin grants gated by RUN and clear_req, and the next write-port values.
    always_comb begin
        grant0       = src0_valid & (~src1_valid | last_grant_q);
        grant1       = src1_valid & (~src0_valid | ~last_grant_q);
        run_open     = (state_q == ST_RUN) & ~clear_req;
        src0_ready   = run_open & grant0;
        src1_ready   = run_open & grant1;
        rf_we_d      = 1'b0;
        rf_dest_d    = rf_dest_q;
        rf_data_d    = rf_data_q;
        last_grant_d = last_grant_q;
        if (state_q == ST_CLEAR) begin
            rf_we_d   = 1'b1;
            rf_dest_d = clr_idx_q;
            rf_data_d = CLEAR_VALUE;
        end else if (src0_ready) begin
            rf_we_d      = 1'b1;
            rf_dest_d    = src0_dest;
            rf_data_d    = src0_data;
            last_grant_d = 1'b0;
        end else if (src1_ready) begin
            rf_we_d      = 1'b1;
            rf_dest_d    = src1_dest;
            rf_data_d    = src1_data;
            last_grant_d = 1'b1;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_regsel_dest = rf_dest_q;
    assign rf_datain      = rf_data_q;
    assign busy           = (state_q == ST_CLEAR);

endmodule
